nibble_serial_adder_ctrl: RTL and testbench
===========================================

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an addition.
REQ-005 SHALL have ports op_a and op_b, input, W each, operands.
REQ-006 SHALL have port cin, input, 1, carry-in to nibble 0.
REQ-007 SHALL have port busy, output, 1, high while an addition is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have ports sum (output, W) and cout (output, 1), the result and the final carry.
REQ-010 SHALL have ports A4, A3, A2, A1, B4, B3, B2, B1 and C0, output, 1 each, driving the downstream 4-bit full adder (binary_full_adder_4bits).
REQ-011 SHALL have ports Sum4, Sum3, Sum2, Sum1 and C4, input, 1 each, returned combinationally from that adder.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL capture op_a, op_b and cin, clear the nibble index to 0, and move to RUN.
REQ-014 RUN: A4..A1 and B4..B1 SHALL be driven from registers with nibble [index] of the captured operands; A4 and B4 are the MSBs of the nibble.
REQ-015 C0 SHALL be the captured cin for index 0 and the registered C4 of the previous nibble for all later nibbles.
REQ-016 Each RUN edge SHALL write Sum4..Sum1 into sum nibble [index], register C4 and increment the index.
REQ-017 On the edge that captures nibble NIBBLES-1, the FSM SHALL enter DONE and cout SHALL take C4.
REQ-018 Latency: with start sampled at edge E0, done SHALL be high exactly for the cycle following edge E0+NIBBLES.
REQ-019 DONE SHALL move unconditionally to IDLE on the next edge.
REQ-020 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-022 start=1 in IDLE on the edge after DONE SHALL be accepted, giving back-to-back operations with one idle cycle between them.
REQ-023 sum and cout SHALL hold the last completed result until the next operation's first capture edge.
REQ-024 sum and cout are valid only when done=1 or when the block is idle after a completed operation.
REQ-025 Adder-side outputs SHALL be 0 in IDLE.
REQ-026 Arithmetic SHALL be unsigned modulo 2^W; the carry out of bit W-1 SHALL appear only on cout.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force state IDLE and index 0.
REQ-028 rst=1 SHALL immediately clear busy, done, sum, cout, A4..A1, B4..B1, C0 and all operand and carry registers to 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Configuration
REQ-030 Macro SUBTRACT_EN SHALL, when defined, add the port sub (input, 1), captured together with start.
REQ-031 With SUBTRACT_EN defined and sub=1, the B operand SHALL be bitwise inverted at capture and the nibble-0 carry SHALL be forced to 1 regardless of cin, giving sum = op_a - op_b mod 2^W and cout = 1 when op_a >= op_b.
REQ-032 Without SUBTRACT_EN, the sub port and its logic SHALL be absent and the block SHALL only add.

Verification
REQ-033 NIBBLES=4, op_a=16'h9999, op_b=16'h9999, cin=0, start pulsed -> sum=16'h3332 and cout=1; done high only in the cycle after edge E0+4.
REQ-034 op_a=16'hFFFF, op_b=16'h0000, cin=1 -> sum=16'h0000, cout=1, and C0=1 on all four nibbles (full carry ripple across nibbles).
REQ-035 op_a=16'h1234, op_b=16'h4321, cin=0, with start held high through RUN -> sum=16'h5555, cout=0, and exactly one done pulse.
REQ-036 rst pulsed at the second RUN cycle of op_a=16'hAAAA, op_b=16'h5555 -> immediately busy=0, done=0, sum=0, no done pulse; a following start with 16'h0001 + 16'h0001 -> sum=16'h0002.
REQ-037 SUBTRACT_EN defined, sub=1, op_a=16'h0005, op_b=16'h0007 -> sum=16'hFFFE, cout=0.
REQ-038 SUBTRACT_EN defined, sub=1, op_a=16'h0007, op_b=16'h0005 -> sum=16'h0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: sequences a W-bit add through an external 4-bit adder, one nibble per clock; SUBTRACT_EN adds a sub port.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
`ifdef SUBTRACT_EN
  input  logic                   sub,
`endif
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   A4,
  output logic                   A3,
  output logic                   A2,
  output logic                   A1,
  output logic                   B4,
  output logic                   B3,
  output logic                   B2,
  output logic                   B1,
  output logic                   C0,
  input  logic                   Sum4,
  input  logic                   Sum3,
  input  logic                   Sum2,
  input  logic                   Sum1,
  input  logic                   C4
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [W-1:0]  a_r, b_r;
  logic [IW-1:0] idx;
  logic          cin_r, c_r, run, last, sub_i;
  logic [3:0]    an, bn;
`ifdef SUBTRACT_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  assign run  = state == RUN;
  assign last = idx == IW'(NIBBLES - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign an   = a_r[{idx, 2'b00} +: 4];
  assign bn   = b_r[{idx, 2'b00} +: 4];
  assign {A4, A3, A2, A1} = run ? an : 4'b0;
  assign {B4, B3, B2, B1} = run ? bn : 4'b0;
  assign C0 = run & (idx == '0 ? cin_r : c_r);
  always_comb begin
    next = state;
    if (state == IDLE) next = start ? RUN : IDLE;
    else if (state == RUN) next = last ? DONE : RUN;
    else next = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // Subtraction is a + ~b + 1, folded into the captured operand and carry.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      cin_r <= 1'b0;
      c_r   <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r   <= op_a;
      b_r   <= sub_i ? ~op_b : op_b;
      cin_r <= cin | sub_i;
      idx   <= '0;
    end else if (run) begin
      sum[{idx, 2'b00} +: 4] <= {Sum4, Sum3, Sum2, Sum1};
      c_r <= C4;
      idx <= idx + 1'b1;
      if (last) cout <= C4;
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed plus random additions checked against plain arithmetic.
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 0, rst = 1, start = 0, cin = 0, sub = 0;
  logic [W-1:0] op_a = 0, op_b = 0, sum;
  logic busy, done, cout;
  logic A4, A3, A2, A1, B4, B3, B2, B1, C0, Sum4, Sum3, Sum2, Sum1, C4;
  int passes = 0, total = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SUBTRACT_EN
    .sub(sub),
`endif
    .op_a(op_a), .op_b(op_b), .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .A4(A4), .A3(A3), .A2(A2), .A1(A1), .B4(B4), .B3(B3), .B2(B2), .B1(B1), .C0(C0),
    .Sum4(Sum4), .Sum3(Sum3), .Sum2(Sum2), .Sum1(Sum1), .C4(C4)
  );

  assign {C4, Sum4, Sum3, Sum2, Sum1} = {1'b0, A4, A3, A2, A1} + {1'b0, B4, B3, B2, B1} + {4'b0, C0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s, input logic hold);
    logic [31:0] be, ce, full, mask, cy;
    logic [W-1:0] prev;
    be = s ? {16'h0, ~b} : {16'h0, b};
    ce = {31'b0, s | c};
    full = {16'h0, a} + be + ce;
    @(negedge clk);
    start = 1; op_a = a; op_b = b; cin = c; sub = s;
    @(negedge clk);
    chk("busy_start", {31'b0, busy}, 1);
    if (!hold) start = 0;
    op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
`ifndef SUBTRACT_EN
    sub = 0;
`endif
    for (int k = 0; k < N; k++) begin
      mask = (32'h1 << (4 * k)) - 1;
      cy = k == 0 ? ce : ((({16'h0, a} & mask) + (be & mask) + ce) >> (4 * k)) & 1;
      chk($sformatf("c0_n%0d", k), {31'b0, C0}, cy);
      chk($sformatf("a_n%0d", k), {28'b0, A4, A3, A2, A1}, ({16'h0, a} >> (4 * k)) & 32'hF);
      chk($sformatf("b_n%0d", k), {28'b0, B4, B3, B2, B1}, (be >> (4 * k)) & 32'hF);
      chk($sformatf("done_low_n%0d", k), {31'b0, done}, 0);
      @(negedge clk);
    end
    chk("done_pulse", {31'b0, done}, 1);
    chk("busy_done", {31'b0, busy}, 1);
    chk("sum", {16'h0, sum}, full & 32'hFFFF);
    chk("cout", {31'b0, cout}, (full >> 16) & 1);
    prev = sum;
    start = 0;
    @(negedge clk);
    chk("done_once", {31'b0, done}, 0);
    chk("busy_idle", {31'b0, busy}, 0);
    chk("sum_hold", {16'h0, sum}, full & 32'hFFFF);
    chk("idle_adder", {23'b0, A4, A3, A2, A1, B4, B3, B2, B1, C0}, 0);
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_sum", {16'h0, sum}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    chk("rst_adder", {23'b0, A4, A3, A2, A1, B4, B3, B2, B1, C0}, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    do_op(16'h9999, 16'h9999, 0, 0, 0);
    do_op(16'hFFFF, 16'h0000, 1, 0, 0);
    do_op(16'h1234, 16'h4321, 0, 0, 1);
    // Abort in the second RUN cycle.
    @(negedge clk);
    start = 1; op_a = 16'hAAAA; op_b = 16'h5555; cin = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_sum", {16'h0, sum}, 0);
    chk("abort_cout", {31'b0, cout}, 0);
    chk("abort_c0", {31'b0, C0}, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", {31'b0, done}, 0);
      @(negedge clk);
    end
    do_op(16'h0001, 16'h0001, 0, 0, 0);
`ifdef SUBTRACT_EN
    do_op(16'h0005, 16'h0007, 0, 1, 0);
    do_op(16'h0007, 16'h0005, 0, 1, 0);
`endif
    for (int i = 0; i < 25; i++) begin
      logic s;
      s = 1'($urandom);
`ifndef SUBTRACT_EN
      s = 0;
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom), s, 1'($urandom));
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
